config_chain_loader: RTL

CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

---
 rtl/fpga250_cfg_pkg.sv | 16 +
 rtl/config_word_serializer.sv | 50 +++++
 rtl/config_chain_loader.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fpga250_cfg_pkg.sv
// Shared fpga250 configuration types: loader FSM states and bitstream/chain defaults.
package fpga250_cfg_pkg;

  localparam int unsigned CFG_WORD_W    = 32;
  localparam int unsigned CFG_CHAIN_LEN = 1024;
  localparam int unsigned CFG_CNT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_SET   = 3'd3,
    ST_DONE  = 3'd4
  } ld_state_e;

endpackage

// File: rtl/config_word_serializer.sv
// Parallel-load, right-shifting word serializer with bit index and last-bit flag.
module config_word_serializer
  import fpga250_cfg_pkg::*;
#(
  parameter int unsigned WORD_W = CFG_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] word,
  output logic              next_bit_c,
  output logic              last_bit_c
);

  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (load) begin
      sr_d  = word;
      idx_d = '0;
    end else if (shift) begin
      sr_d  = sr_q >> 1;
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

  // Look-ahead bit lets the owner register shift_out in step with the shifter.
  assign next_bit_c = sr_d[0];
  assign last_bit_c = (idx_q == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/config_chain_loader.sv
// Streams bitstream words LSB-first into a configuration shift chain, then commits with set_out.
module config_chain_loader
  import fpga250_cfg_pkg::*;
#(
  parameter int unsigned WORD_W    = CFG_WORD_W,
  parameter int unsigned CHAIN_LEN = CFG_CHAIN_LEN,
  parameter int unsigned CNT_W     = CFG_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cen,
  output logic              shift_out,
  output logic              set_out,
  output logic              busy,
  output logic              done
);

  ld_state_e        state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             ser_clear, ser_load, ser_shift;
  logic             next_bit_c, last_bit_c;

  logic word_ready_q, word_ready_d;
  logic cen_q, cen_d;
  logic shift_out_q, shift_out_d;
  logic set_out_q, set_out_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  config_word_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .clear      (ser_clear),
    .load       (ser_load),
    .shift      (ser_shift),
    .word       (word_data),
    .next_bit_c (next_bit_c),
    .last_bit_c (last_bit_c)
  );

  // Next state, chain counter and serializer controls; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    ser_clear = 1'b0;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          bit_cnt_d = '0;
          ser_clear = 1'b1;
        end
      end
      ST_LOAD: begin
        if (word_valid) begin
          ser_load = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ser_shift = 1'b1;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
          state_d = ST_SET;
        end else if (last_bit_c) begin
          state_d = ST_LOAD;
        end
      end
      ST_SET:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d   = ST_IDLE;
      ser_clear = 1'b0;
      ser_load  = 1'b0;
      ser_shift = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they change with the state register.
  always_comb begin
    word_ready_d = (state_d == ST_LOAD);
    cen_d        = (state_d == ST_SHIFT);
    shift_out_d  = (state_d == ST_SHIFT) ? next_bit_c : 1'b0;
    set_out_d    = (state_d == ST_SET);
    busy_d       = (state_d == ST_LOAD) || (state_d == ST_SHIFT) || (state_d == ST_SET);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      word_ready_q <= 1'b0;
      cen_q        <= 1'b0;
      shift_out_q  <= 1'b0;
      set_out_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_ready_q <= word_ready_d;
      cen_q        <= cen_d;
      shift_out_q  <= shift_out_d;
      set_out_q    <= set_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign word_ready = word_ready_q;
  assign cen        = cen_q;
  assign shift_out  = shift_out_q;
  assign set_out    = set_out_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
